// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - single-clock first-word-fall-through FIFO with flags, count and overflow pulse
module sync_fifo_fwft #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4,
  parameter int AFULL_THR  = 12,
  parameter int AEMPTY_THR = 2
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [WIDTH-1:0]      DIN,
  input  logic                  DIN_DV,
  output logic                  DIN_RDY,
  output logic [WIDTH-1:0]      DOUT,
  output logic                  DOUT_DV,
  input  logic                  DOUT_RDY,
  output logic [DEPTH_LOG2:0]   COUNT,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic                  AFULL,
  output logic                  AEMPTY,
  output logic                  OVERFLOW
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  if (DEPTH_LOG2 < 2) begin : g_bad_depth
    $error("sync_fifo_fwft: DEPTH_LOG2 must be at least 2");
  end
  if (AFULL_THR < 1 || AFULL_THR > DEPTH) begin : g_bad_afull
    $error("sync_fifo_fwft: AFULL_THR must be in 1..DEPTH");
  end
  if (AEMPTY_THR < 0 || AEMPTY_THR > DEPTH - 1) begin : g_bad_aempty
    $error("sync_fifo_fwft: AEMPTY_THR must be in 0..DEPTH-1");
  end

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  wr_en, rd_en;

  // Writes are refused at full even when a pop frees a slot in the same cycle.
  always_comb begin
    wr_en      = DIN_DV && !FULL;
    rd_en      = DOUT_RDY && DOUT_DV;
    wr_ptr_d   = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
    overflow_d = DIN_DV && FULL;
    count_d    = count_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: nothing is presented unless count_q says it is live.
  always_ff @(posedge CLK) begin
    if (wr_en) mem_q[wr_ptr_q] <= DIN;
  end

  assign COUNT    = count_q;
  assign FULL     = (count_q == CW'(DEPTH));
  assign EMPTY    = (count_q == '0);
  assign AFULL    = (count_q >= CW'(AFULL_THR));
  assign AEMPTY   = (count_q <= CW'(AEMPTY_THR));
  assign DIN_RDY  = !FULL;
  assign DOUT_DV  = !EMPTY;
  assign DOUT     = DOUT_DV ? mem_q[rd_ptr_q] : '0;
  assign OVERFLOW = overflow_q;

endmodule
